// File: rtl/output_collector.sv
// Collects streamed result samples into a small write queue and drains them to external memory.
// Optional running checksum of accepted samples: define OUTPUT_COLLECTOR_CHECKSUM_EN.
module output_collector #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int EXT_MEM_HEIGHT     = 1 << 20,
  parameter int EXT_MEM_WIDTH      = 32,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int FIFO_DEPTH         = 4,
  parameter int BASE_ADDR          = 0,
  localparam int AW    = $clog2(EXT_MEM_HEIGHT),
  localparam int XW    = (FEATURE_MAP_WIDTH > 1) ? $clog2(FEATURE_MAP_WIDTH) : 1,
  localparam int YW    = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
  localparam int CHW   = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1,
  localparam int TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS,
  localparam int CW    = $clog2(TOTAL + 1)
) (
  input  logic                            clk,
  input  logic                            arst_n_in,
  input  logic                            start,
  input  logic signed [IO_DATA_WIDTH-1:0] out,
  input  logic                            output_valid,
  input  logic [XW-1:0]                   output_x,
  input  logic [YW-1:0]                   output_y,
  input  logic [CHW-1:0]                  output_ch,
  input  logic                            mem_grant,
  output logic [AW-1:0]                   mem_write_addr,
  output logic [EXT_MEM_WIDTH-1:0]        mem_din,
  output logic                            mem_write_en,
  output logic                            running,
  output logic                            done,
  output logic                            overflow,
  output logic [CW-1:0]                   count,
  output logic [31:0]                     checksum
);

  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;
  localparam int EW = AW + EXT_MEM_WIDTH;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [EW-1:0]       fifo_q [FIFO_DEPTH];
  logic [EW-1:0]       fifo_d [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                fifo_empty, fifo_full;
  logic                arm, push, pop, drop;
  logic [AW-1:0]       sample_addr;
  logic [EXT_MEM_WIDTH-1:0] sample_data;
  logic [EW-1:0]       fifo_head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);

  assign arm  = start && ((state_q == IDLE) || (state_q == DONE));
  assign pop  = !fifo_empty && mem_grant;
  // A full queue still accepts a sample when the head leaves in the same cycle.
  assign push = (state_q == COLLECT) && output_valid && (!fifo_full || pop);
  assign drop = (state_q == COLLECT) && output_valid && !push;

  // Channel-innermost addressing; arithmetic wraps naturally at AW bits.
  assign sample_addr = AW'(BASE_ADDR)
                     + ((AW'(output_y) * AW'(FEATURE_MAP_WIDTH) + AW'(output_x))
                        * AW'(OUTPUT_NB_CHANNELS))
                     + AW'(output_ch);
  assign sample_data = EXT_MEM_WIDTH'(out);

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q[IW-1:0]] = {sample_addr, sample_data};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // DRAIN finishes as soon as the last entry leaves, so done follows the final write directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (arm) state_d = COLLECT;
      COLLECT:    if (push && (count_q == CW'(TOTAL - 1))) state_d = DRAIN;
      DRAIN:      if (wr_ptr_d == rd_ptr_d) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (arm) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) count_d    = count_q + 1'b1;
      if (drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

`ifdef OUTPUT_COLLECTOR_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (arm) begin
      checksum_d = '0;
    end else if (push) begin
      checksum_d = checksum_q + 32'(out);
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  // Queue storage is not reset, so the head is masked while the queue is empty.
  assign fifo_head      = fifo_q[rd_ptr_q[IW-1:0]];
  assign mem_write_en   = pop;
  assign mem_write_addr = fifo_empty ? '0 : fifo_head[EW-1:EXT_MEM_WIDTH];
  assign mem_din        = fifo_empty ? '0 : fifo_head[EXT_MEM_WIDTH-1:0];
  assign running        = (state_q == COLLECT) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign overflow       = overflow_q;
  assign count          = count_q;

endmodule

// File: doc/output_collector.md
OUTPUT_COLLECTOR -- requirements
Module: output_collector

Interface
REQ-001 SHALL have parameter IO_DATA_WIDTH, default 16, the width of the result sample.
REQ-002 SHALL have parameter EXT_MEM_HEIGHT, default 1<<20, the memory depth; address width AW = $clog2(EXT_MEM_HEIGHT).
REQ-003 SHALL have parameter EXT_MEM_WIDTH, default 32, the memory word width.
REQ-004 SHALL have parameters FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT and OUTPUT_NB_CHANNELS, defaults 1024/1024/64, the output tensor shape; TOTAL = W*H*C.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, power of two, at least 2: the number of write-queue entries.
REQ-006 SHALL have parameter BASE_ADDR, default 0, the memory base address of the output tensor.
REQ-007 clk  in  1  the single clock; all state rises on posedge.
REQ-008 arst_n_in  in  1  one clock; reset is asynchronous and active-low.
REQ-009 start  in  1  single-cycle pulse that arms collection.
REQ-010 out  in  IO_DATA_WIDTH  signed result sample.
REQ-011 output_valid  in  1  qualifies out and its coordinates; there is no ready (producer cannot stall).
REQ-012 output_x, output_y, output_ch  in  $clog2 of W/H/C  coordinates of the sample.
REQ-013 mem_grant  in  1  the external write port is available this cycle.
REQ-014 mem_write_addr  out  AW  write address.
REQ-015 mem_din  out  EXT_MEM_WIDTH  write data.
REQ-016 mem_write_en  out  1  write strobe.
REQ-017 running  out  1  high in COLLECT or DRAIN.
REQ-018 done  out  1  high in DONE.
REQ-019 overflow  out  1  sticky flag: a sample was dropped.
REQ-020 count  out  $clog2(TOTAL+1)  number of samples accepted.
REQ-021 checksum  out  32  running sum of accepted samples (see Configuration).

Function
REQ-022 States: IDLE, COLLECT, DRAIN, DONE.
- IDLE/DONE + start -> COLLECT; count, overflow and checksum clear.
- start in COLLECT or DRAIN is ignored.
REQ-023 In COLLECT, a sample with output_valid=1 SHALL be pushed as {addr, data} when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-024 Otherwise the sample SHALL be dropped and overflow set; count does not increment.
REQ-025 addr SHALL be BASE_ADDR + (y*W + x)*C + ch, truncated to AW bits (channel innermost).
REQ-026 data SHALL be out sign-extended to EXT_MEM_WIDTH.
REQ-027 count SHALL increment per push; on the push that makes count == TOTAL the state SHALL go to DRAIN the next cycle.
REQ-028 output_valid SHALL be ignored in IDLE, DRAIN and DONE: no push, no overflow.
REQ-029 mem_write_en = FIFO non-empty AND mem_grant, combinational from mem_grant.
REQ-030 mem_write_addr and mem_din SHALL present the FIFO head; a pop occurs when mem_write_en=1.
REQ-031 Minimum latency: a sample accepted at edge t SHALL be written in the cycle after t; FIFO order SHALL be preserved.
REQ-032 DRAIN -> DONE when the FIFO is empty; done SHALL hold until the next start.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-034 While arst_n_in=0, state SHALL be IDLE, the FIFO empty and pointers 0, and all outputs 0 (mem_write_en=0 regardless of mem_grant).
REQ-035 Reset mid-operation SHALL discard queued entries; no write SHALL occur after reset until a new start.

Configuration
REQ-036 With OUTPUT_COLLECTOR_CHECKSUM_EN defined, checksum SHALL add each pushed sample, sign-extended to 32 bits, modulo 2^32.
REQ-037 Without OUTPUT_COLLECTOR_CHECKSUM_EN, checksum SHALL be constant 0 with no accumulator; the port is present in both cases.

Verification (W=H=C=2, TOTAL=8, FIFO_DEPTH=4, BASE_ADDR=0)
REQ-038 Reset test: assert arst_n_in=0 with mem_grant=1 -> every output is 0.
REQ-039 Normal collection: start, then 8 consecutive valid samples with grant=1; the last is x=1,y=1,ch=1,out=-5 -> a write at addr 7 with din 0xFFFFFFFB, count=8, then done=1 the cycle after the last write.
REQ-040 Stalled port: start, grant=0, 6 valid samples -> 4 queued, overflow=1, count=4; grant=1 -> 4 writes in order.
REQ-041 Full with pop: FIFO full, grant=1 and valid in the same cycle -> sample accepted, overflow stays 0.
REQ-042 Reset in DRAIN: assert arst_n_in mid-DRAIN -> mem_write_en=0, state IDLE, and no further writes.
REQ-043 Checksum: with the macro, samples 3, -1, 5 -> checksum=7; without the macro -> checksum=0.
